// File: rtl/axi_mem_master_if.sv
// axi_mem_master bus bundle: CPU request/response port
// plus the AXI-lite read and write channels.
interface axi_mem_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  localparam int STRB_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wmask;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              resp_we;

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_wmask,
    output req_ready,
    output resp_valid, resp_rdata,
    output resp_err, resp_we,
    input  resp_ready,
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid,
    output awaddr, awvalid,
    output wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    output req_valid, req_we, req_addr,
    output req_wdata, req_wmask,
    input  req_ready,
    input  resp_valid, resp_rdata,
    input  resp_err, resp_we,
    output resp_ready,
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid,
    input  awaddr, awvalid,
    input  wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_mem_master.sv
// axi_mem_master: single-outstanding bridge from the CPU
// memory request port to an AXI-lite slave.
module axi_mem_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int ALIGN_BITS = 3
) (
  input logic              aclk,
  input logic              areset,
  axi_mem_master_if.master bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    ~((ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1));

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_awvalid;
  logic              r_wvalid;
  logic              r_bready;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic              r_resp_we;
  logic [DATA_W-1:0] r_resp_rdata;
  logic [ADDR_W-1:0] r_araddr;
  logic [ADDR_W-1:0] r_awaddr;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;

  logic w_ar_hs;
  logic w_r_hs;
  logic w_b_hs;
  logic w_aw_done;
  logic w_w_done;
  logic [ADDR_W-1:0] w_addr_al;

  assign w_ar_hs   = r_arvalid & bus.arready;
  assign w_r_hs    = r_rready & bus.rvalid;
  assign w_b_hs    = r_bready & bus.bvalid;
  // a channel is done if it already handshook
  // or is handshaking this cycle
  assign w_aw_done = ~r_awvalid | bus.awready;
  assign w_w_done  = ~r_wvalid | bus.wready;
  assign w_addr_al = bus.req_addr & ALIGN_MASK;

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_we    = r_resp_we;
  assign bus.araddr     = r_araddr;
  assign bus.arvalid    = r_arvalid;
  assign bus.rready     = r_rready;
  assign bus.awaddr     = r_awaddr;
  assign bus.awvalid    = r_awvalid;
  assign bus.wdata      = r_wdata;
  assign bus.wstrb      = r_wstrb;
  assign bus.wvalid     = r_wvalid;
  assign bus.bready     = r_bready;

  // state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state selection from the channel handshakes
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:
        if (bus.req_valid)
          w_state_nxt = bus.req_we ? WR_REQ : RD_ADDR;
      RD_ADDR: if (w_ar_hs) w_state_nxt = RD_DATA;
      RD_DATA: if (w_r_hs)  w_state_nxt = RESP;
      WR_REQ:
        if (w_aw_done && w_w_done)
          w_state_nxt = WR_RESP;
      WR_RESP: if (w_b_hs) w_state_nxt = RESP;
      RESP:
        if (bus.resp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // registered channel valids/readys and payloads
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_we    <= 1'b0;
      r_resp_rdata <= '0;
      r_araddr     <= '0;
      r_awaddr     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
    end else begin
      unique case (r_state)
        IDLE:
          if (bus.req_valid) begin
            if (bus.req_we) begin
              r_awaddr  <= w_addr_al;
              r_wdata   <= bus.req_wdata;
              r_wstrb   <= bus.req_wmask;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_araddr  <= w_addr_al;
              r_arvalid <= 1'b1;
            end
          end
        RD_ADDR:
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        RD_DATA:
          if (w_r_hs) begin
            r_resp_rdata <= bus.rdata;
            r_resp_err   <= |bus.rresp;
            r_resp_we    <= 1'b0;
            r_rready     <= 1'b0;
            r_resp_valid <= 1'b1;
          end
        WR_REQ: begin
          if (bus.awready) r_awvalid <= 1'b0;
          if (bus.wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done)
            r_bready <= 1'b1;
        end
        WR_RESP:
          if (w_b_hs) begin
            r_resp_err   <= |bus.bresp;
            r_resp_rdata <= '0;
            r_resp_we    <= 1'b1;
            r_bready     <= 1'b0;
            r_resp_valid <= 1'b1;
          end
        RESP:
          if (bus.resp_ready) r_resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_mem_master.sv
// tb_axi_mem_master: random + directed traffic through a
// latency-programmable AXI-lite slave, scoreboard checked.
module tb_axi_mem_master;
  logic clk;
  logic rst;

  axi_mem_master_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  axi_mem_master #(
    .ADDR_W(32), .DATA_W(64), .ALIGN_BITS(3)
  ) dut (
    .aclk  (clk),
    .areset(rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic        err;
    logic [63:0] rdata;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails  = 0;

  int ar_lat = 0, r_lat = 0, aw_lat = 0;
  int w_lat = 0, b_lat = 0;
  logic [1:0] r_code = 2'b00, b_code = 2'b00;
  int rr_hold = 0;
  bit rr_rand = 1'b0;

  logic [31:0] obs_addr = '0;
  logic [63:0] obs_wdata = '0;
  logic [7:0]  obs_wstrb = '0;

  logic [63:0] s_mem [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];

  function automatic void chk(input string n,
    input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h",
        n, act, exp);
    end
  endfunction

  function automatic logic [63:0] init_word(
    input logic [31:0] a);
    return {a, a ^ 32'hA5A5_5A5A};
  endfunction

  function automatic logic [7:0] init_byte(
    input logic [31:0] b);
    logic [63:0] w;
    int sh;
    w = init_word({b[31:3], 3'b000});
    sh = 8 * int'(b[2:0]);
    return w[sh +: 8];
  endfunction

  // reference model: byte-addressed memory
  function automatic logic [63:0] ref_read(
    input logic [31:0] a);
    logic [63:0] v;
    logic [31:0] b;
    for (int i = 0; i < 8; i++) begin
      b = a + 32'(i);
      if (ref_mem.exists(b)) v[8*i +: 8] = ref_mem[b];
      else v[8*i +: 8] = init_byte(b);
    end
    return v;
  endfunction

  function automatic void ref_write(input logic [31:0] a,
    input logic [63:0] d, input logic [7:0] m);
    for (int i = 0; i < 8; i++)
      if (m[i]) ref_mem[a + 32'(i)] = d[8*i +: 8];
  endfunction

  // slave storage: word-addressed
  function automatic logic [63:0] s_read(
    input logic [31:0] a);
    if (s_mem.exists(a)) return s_mem[a];
    return init_word(a);
  endfunction

  function automatic void s_write(input logic [31:0] a,
    input logic [63:0] d, input logic [7:0] m);
    logic [63:0] w;
    w = s_read(a);
    for (int i = 0; i < 8; i++)
      if (m[i]) w[8*i +: 8] = d[8*i +: 8];
    s_mem[a] = w;
  endfunction

  // AXI-lite slave, acts on falling edges
  initial begin : slave
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit r_pend, aw_got, w_got, b_pend;
    logic [31:0] ar_first, r_addr, aw_first, w_addr;
    logic [63:0] w_first_d;
    logic [7:0]  w_first_s;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0;
    w_cnt = 0; b_cnt = 0;
    r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
    ar_first = '0; r_addr = '0;
    aw_first = '0; w_addr = '0;
    w_first_d = '0; w_first_s = '0;
    bus.arready = 0; bus.rvalid = 0;
    bus.rdata = '0; bus.rresp = '0;
    bus.awready = 0; bus.wready = 0;
    bus.bvalid = 0; bus.bresp = '0;
    forever begin
      @(negedge clk);
      if (bus.rvalid) bus.rvalid = 0;
      else if (r_pend) begin
        if (r_cnt < r_lat) r_cnt++;
        else begin
          bus.rvalid = 1;
          bus.rdata = s_read(r_addr);
          bus.rresp = r_code;
          r_pend = 0;
        end
      end
      bus.arready = 0;
      if (bus.arvalid) begin
        if (ar_cnt == 0) ar_first = bus.araddr;
        else chk("araddr_stable", 64'(bus.araddr),
          64'(ar_first));
        if (ar_cnt < ar_lat) ar_cnt++;
        else begin
          bus.arready = 1;
          ar_cnt = 0;
          r_pend = 1;
          r_cnt = 0;
          r_addr = bus.araddr;
          obs_addr = bus.araddr;
        end
      end
      if (bus.bvalid) bus.bvalid = 0;
      else if (b_pend) begin
        if (b_cnt < b_lat) b_cnt++;
        else begin
          bus.bvalid = 1;
          bus.bresp = b_code;
          if (b_code == 2'b00)
            s_write(w_addr, obs_wdata, obs_wstrb);
          b_pend = 0;
        end
      end
      bus.awready = 0;
      if (bus.awvalid) begin
        if (aw_cnt == 0) aw_first = bus.awaddr;
        else chk("awaddr_stable", 64'(bus.awaddr),
          64'(aw_first));
        if (aw_cnt < aw_lat) aw_cnt++;
        else begin
          bus.awready = 1;
          aw_cnt = 0;
          aw_got = 1;
          w_addr = bus.awaddr;
          obs_addr = bus.awaddr;
        end
      end
      bus.wready = 0;
      if (bus.wvalid) begin
        if (w_cnt == 0) begin
          w_first_d = bus.wdata;
          w_first_s = bus.wstrb;
        end else begin
          chk("wdata_stable", bus.wdata, w_first_d);
          chk("wstrb_stable", 64'(bus.wstrb),
            64'(w_first_s));
        end
        if (w_cnt < w_lat) w_cnt++;
        else begin
          bus.wready = 1;
          w_cnt = 0;
          w_got = 1;
          obs_wdata = bus.wdata;
          obs_wstrb = bus.wstrb;
        end
      end
      if (aw_got && w_got) begin
        aw_got = 0;
        w_got = 0;
        b_pend = 1;
        b_cnt = 0;
      end
    end
  end

  // response consumer back-pressure
  initial begin : rr_gen
    bus.resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (bus.resp_valid && rr_hold > 0) begin
        bus.resp_ready = 1'b0;
        rr_hold--;
      end else if (rr_rand)
        bus.resp_ready = 1'($urandom_range(0, 1));
      else
        bus.resp_ready = 1'b1;
    end
  end

  // monitor: pops the scoreboard on each response
  initial begin : monitor
    bit held;
    logic [63:0] h_rdata;
    logic h_err, h_we;
    exp_t e;
    held = 0;
    h_rdata = '0; h_err = 0; h_we = 0;
    forever begin
      @(negedge clk);
      if (bus.resp_valid) begin
        chk("req_ready_in_resp", 64'(bus.req_ready), 64'd0);
        if (held) begin
          chk("resp_rdata_stable", bus.resp_rdata, h_rdata);
          chk("resp_err_stable", 64'(bus.resp_err),
            64'(h_err));
          chk("resp_we_stable", 64'(bus.resp_we),
            64'(h_we));
        end
        if (bus.resp_ready) begin
          held = 0;
          if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_resp actual=resp_valid expected=none");
          end else begin
            e = sb.pop_front();
            chk("resp_rdata", bus.resp_rdata, e.rdata);
            chk("resp_err", 64'(bus.resp_err), 64'(e.err));
            chk("resp_we", 64'(bus.resp_we), 64'(e.we));
            chk("axi_addr", 64'(obs_addr), 64'(e.addr));
            if (e.we) begin
              chk("wdata", obs_wdata, e.wdata);
              chk("wstrb", 64'(obs_wstrb), 64'(e.wstrb));
            end
          end
        end else begin
          held = 1;
          h_rdata = bus.resp_rdata;
          h_err = bus.resp_err;
          h_we = bus.resp_we;
        end
      end else held = 0;
    end
  end

  task automatic do_txn(input logic we,
    input logic [31:0] addr, input logic [63:0] wd,
    input logic [7:0] wm, input logic [1:0] code,
    input int al, input int rl, input int awl,
    input int wl, input int bl);
    exp_t e;
    int t;
    @(negedge clk);
    t = 0;
    while (!bus.req_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) begin
      checks++;
      fails++;
      $display("FAIL req_accept_timeout actual=0 expected=1");
      return;
    end
    ar_lat = al; r_lat = rl; aw_lat = awl;
    w_lat = wl; b_lat = bl;
    r_code = code; b_code = code;
    e.addr = addr & 32'hFFFF_FFF8;
    e.we = we;
    e.err = (code != 2'b00);
    e.wdata = wd;
    e.wstrb = wm;
    if (we) begin
      e.rdata = '0;
      if (code == 2'b00) ref_write(e.addr, wd, wm);
    end else e.rdata = ref_read(e.addr);
    sb.push_back(e);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = addr;
    bus.req_wdata = wd;
    bus.req_wmask = wm;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || !bus.req_ready) && t < 2000)
    begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0 || !bus.req_ready) begin
      checks++;
      fails++;
      $display("FAIL idle_timeout actual=%0d pending expected=0",
        sb.size());
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cyc;
    int t;
    logic [31:0] a;
    logic [1:0] c;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'({bus.arvalid, bus.rready,
      bus.awvalid, bus.wvalid, bus.bready, bus.resp_valid,
      bus.resp_err, bus.resp_we}), 64'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
    chk("rst_araddr", 64'(bus.araddr), 64'd0);
    chk("rst_awaddr", 64'(bus.awaddr), 64'd0);
    chk("rst_wdata", bus.wdata, 64'd0);
    chk("rst_wstrb", 64'(bus.wstrb), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    rst = 1'b0;

    s_mem[32'h1000] = 64'h1122_3344_5566_7788;
    ref_write(32'h1000, 64'h1122_3344_5566_7788, 8'hFF);
    do_txn(0, 32'h1000, '0, '0, 2'b00, 0, 0, 0, 0, 0);
    cyc = 1;
    while (!bus.resp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("read_latency", 64'(cyc), 64'd3);
    wait_idle();

    do_txn(0, 32'h8000_0013, '0, '0, 2'b00, 3, 1, 0, 0, 0);
    wait_idle();

    do_txn(1, 32'h2000, 64'hDEAD_BEEF_0000_0000, 8'hF0,
      2'b00, 0, 0, 0, 2, 1);
    wait_idle();
    do_txn(0, 32'h2004, '0, '0, 2'b00, 0, 0, 0, 0, 0);
    wait_idle();

    do_txn(1, 32'h3000, 64'h0123_4567_89AB_CDEF, 8'hFF,
      2'b10, 1, 0, 1, 0, 0);
    wait_idle();
    do_txn(0, 32'h3000, '0, '0, 2'b11, 0, 2, 0, 0, 0);
    wait_idle();

    rr_hold = 4;
    do_txn(0, 32'h2000, '0, '0, 2'b00, 0, 0, 0, 0, 0);
    do_txn(1, 32'h2008, 64'hCAFE_F00D_1234_5678, 8'h3C,
      2'b00, 0, 0, 1, 0, 0);
    do_txn(0, 32'h2008, '0, '0, 2'b00, 1, 1, 0, 0, 0);
    wait_idle();

    do_txn(0, 32'h8000_0040, '0, '0, 2'b00, 0, 6, 0, 0, 0);
    t = 0;
    while (!bus.rready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("in_rd_data", 64'(bus.rready), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", 64'({bus.arvalid, bus.rready,
      bus.awvalid, bus.wvalid, bus.bready,
      bus.resp_valid}), 64'd0);
    chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
    if (sb.size() > 0) void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    do_txn(0, 32'h1000, '0, '0, 2'b00, 0, 0, 0, 0, 0);
    wait_idle();

    rr_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      a = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 24)
        | 32'($urandom_range(0, 63));
      c = ($urandom_range(0, 7) == 0) ?
        2'($urandom_range(1, 3)) : 2'b00;
      do_txn(1'($urandom_range(0, 1)), a,
        {$urandom, $urandom}, 8'($urandom), c,
        $urandom_range(0, 3), $urandom_range(0, 3),
        $urandom_range(0, 3), $urandom_range(0, 3),
        $urandom_range(0, 3));
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d",
      checks, fails);
    $finish;
  end
endmodule

// File: doc/axi_mem_master.md
Name: axi_mem_master

Overview:
- Single-outstanding AXI-lite master bridge between the CPU load/store/fetch request port and the simulation SRAM slave.
- Accepts one simple valid/ready memory request and drives the matching AXI read (AR/R) or write (AW/W/B) channels.
- Returns read data or write completion on a valid/ready response port.
- Flags any non-OKAY AXI response as an error.

Parameters:
- ADDR_W, 32, AXI/request address width.
- DATA_W, 64, data width in bits; STRB width = DATA_W/8.
- ALIGN_BITS, 3, low address bits zeroed on araddr/awaddr (log2 of DATA_W/8).

Ports:
- aclk  in  1  clock, all state on rising edge
- areset  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  bridge can accept a request
- req_we  in  1  1=write, 0=read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data, already lane-aligned by the CPU
- req_wmask  in  DATA_W/8  byte write strobes
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  DATA_W  read data (0 for writes)
- resp_err  out  1  rresp/bresp was non-zero
- resp_we  out  1  echo of req_we for the response
- araddr  out  ADDR_W, arvalid  out  1, arready  in  1
- rdata  in  DATA_W, rresp  in  2, rvalid  in  1, rready  out  1
- awaddr  out  ADDR_W, awvalid  out  1, awready  in  1
- wdata  out  DATA_W, wstrb  out  DATA_W/8, wvalid  out  1, wready  in  1
- bresp  in  2, bvalid  in  1, bready  out  1

Behaviour:
- Reset (async, while areset=1): state=IDLE; arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err, resp_we = 0; resp_rdata, araddr, awaddr, wdata, wstrb = 0.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- req_ready = (state==IDLE), combinational; no other state accepts requests.
- IDLE:
  - req_valid & req_we=0: latch araddr = req_addr with low ALIGN_BITS zeroed; set arvalid=1; go RD_ADDR.
  - req_valid & req_we=1: latch awaddr (aligned), wdata, wstrb; set awvalid=wvalid=1; go WR_REQ.
- RD_ADDR: hold arvalid and araddr stable until arready; on arvalid&arready, arvalid<=0, rready<=1, go RD_DATA.
- RD_DATA: rready=1; on rvalid&rready, capture resp_rdata=rdata, resp_err=(rresp!=0), resp_we=0; rready<=0; resp_valid<=1; go RESP.
- WR_REQ:
  - awvalid drops on awready; wvalid drops on wready, each independently.
  - Both handshakes in the same cycle are allowed.
  - Once both complete (current-cycle handshakes included), bready<=1, go WR_RESP.
  - Payload stays stable while its valid is high.
- WR_RESP: on bvalid&bready, resp_err=(bresp!=0), resp_rdata=0, resp_we=1; bready<=0; resp_valid<=1; go RESP.
- RESP: hold resp_* stable while resp_valid=1 & resp_ready=0; on resp_ready, resp_valid<=0, go IDLE. Next request is accepted no earlier than the following cycle.
- Valids never depend combinationally on readys; no valid is withdrawn before its handshake.
- Minimum read latency with arready=1 and a 1-cycle slave: accept at cycle 0, arvalid at 1, rvalid at 2, resp_valid at 3.
- Upper address bits pass through unmodified; address translation is the slave's job.
- Reset mid-transaction aborts immediately. All valids/readys go low and state returns to IDLE. Any late slave response after reset is ignored, because rready=bready=0.

Test Plan:
- Read with arready=1 and 1-cycle rvalid, rdata=0x1122334455667788, rresp=0 -> resp_valid at cycle 3, resp_rdata=0x1122334455667788, resp_err=0, resp_we=0.
- Read with req_addr=0x80000013 -> araddr=0x80000010, held stable under 3 cycles of arready=0.
- Write with wdata=0xDEADBEEF00000000, wmask=0xF0; awready 2 cycles before wready; bvalid 1 cycle later -> single resp_valid with resp_we=1, resp_err=0, resp_rdata=0; wstrb=0xF0 throughout.
- bresp=2'b10 on write and rresp=2'b11 on read -> resp_err=1 for each.
- resp_ready held low 4 cycles -> resp fields stable and req_ready=0 until release; then back-to-back read-write-read completes in order.
- areset pulsed while in RD_DATA -> all AXI valids/readys and resp_valid = 0 in the same cycle; a following rvalid is ignored; the next request completes normally.
